rr_mux_arbiter_4: RTL

- Round-robin arbiter that shares one 4:1 data mux and one registered output channel among four requesters.
- Each requester presents valid/data and receives ready; the winner's data is steered through the mux into an output register with valid/ready handshake.
- Grants persist for bursts of up to MAX_BURST transfers, then rotate; sits between four producers and a single downstream consumer.

---
 rtl/rr_mux_arbiter_4_if.sv | 26 ++
 rtl/rr_mux_arbiter_4.sv | 112 +++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_4_if.sv
// Handshake bundle between four producers, the round-robin arbiter and one consumer.
// The slave side is the arbiter. The master side is the producers plus the downstream sink.
interface rr_mux_arbiter_4_if #(
   parameter int W = 4
);
   logic [3:0]   in_valid;
   logic [W-1:0] d0;
   logic [W-1:0] d1;
   logic [W-1:0] d2;
   logic [W-1:0] d3;
   logic [3:0]   in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_id;
   logic         out_ready;

   modport slave (
      input  in_valid, d0, d1, d2, d3, out_ready,
      output in_ready, out_valid, out_data, out_id
   );

   modport master (
      output in_valid, d0, d1, d2, d3, out_ready,
      input  in_ready, out_valid, out_data, out_id
   );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter that steers one of four requesters through an AND/OR mux into a
// registered output channel. A grant lasts for up to MAX_BURST beats and then rotates.
module rr_mux_arbiter_4 #(
   parameter int W         = 4,
   parameter int MAX_BURST = 4
) (
   input logic               clk,
   input logic               rst,
   rr_mux_arbiter_4_if.slave bus
);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [1:0]     r_grant;
   logic [1:0]     r_ptr;
   logic [CW-1:0]  r_burst_cnt;
   logic           r_out_valid;
   logic [W-1:0]   r_out_data;
   logic [1:0]     r_out_id;

   logic [1:0]     w_pick;
   logic           w_any;
   logic           w_out_free;
   logic [3:0]     w_in_ready;
   logic           w_xfer;
   logic           w_last;
   logic           w_rel;
   logic [W-1:0]   w_mux;

   // Rotating priority scan: the lowest offset from r_ptr wins, so iterate high to low.
   always_comb begin : pick_scan
      logic [1:0] v_idx;
      v_idx  = r_ptr;
      w_pick = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         v_idx = r_ptr + 2'(k);
         if (bus.in_valid[v_idx]) w_pick = v_idx;
      end
   end

   assign w_any      = |bus.in_valid;
   assign w_out_free = ~r_out_valid | bus.out_ready;
   assign w_xfer     = bus.in_valid[r_grant] & w_in_ready[r_grant];
   assign w_last     = (r_burst_cnt == CW'(MAX_BURST - 1));
   assign w_rel      = (r_state == S_GRANT) & ((w_xfer & w_last) | ~bus.in_valid[r_grant]);

   assign w_mux = ({W{r_grant == 2'd0}} & bus.d0) |
                  ({W{r_grant == 2'd1}} & bus.d1) |
                  ({W{r_grant == 2'd2}} & bus.d2) |
                  ({W{r_grant == 2'd3}} & bus.d3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
         S_GRANT: if (w_rel) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // in_ready sees only registered state and out_ready, never in_valid.
   always_comb begin
      w_in_ready = 4'b0000;
      if (r_state == S_GRANT && w_out_free) w_in_ready[r_grant] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant     <= 2'd0;
         r_ptr       <= 2'd0;
         r_burst_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_any) begin
            r_grant     <= w_pick;
            r_burst_cnt <= '0;
         end
      end else if (w_rel) begin
         r_ptr       <= r_grant + 2'd1;
         r_burst_cnt <= '0;
      end else if (w_xfer) begin
         r_burst_cnt <= r_burst_cnt + CW'(1);
      end
   end

   // Output stage: reload on transfer, drain when accepted, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= 2'd0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_mux;
         r_out_id    <= r_grant;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_id    = r_out_id;
endmodule
